fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  RV32I instruction-fetch stage with IF/ID register. Sits directly upstream of
//  the hazard unit: takes its stallF/stallD/flushD and the EX redirect
//  (PCSrcE/PCTargetE), talks to instruction memory over a valid/ready
//  request + response-valid interface, and produces InstrD/PCD/PCPlus4D for decode.
//  At most one imem request is outstanding.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h0000_0000 PC value loaded at reset
//  NOP_INSTR 32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk              in   1     clock; all state updates on posedge
//  rst              in   1     synchronous, active-high reset
//  stallF           in   1     hold PCF, do not issue new request
//  stallD           in   1     hold IF/ID register contents
//  flushD           in   1     clear IF/ID register to bubble
//  PCSrcE           in   1     taken branch/jump redirect from EX
//  PCTargetE        in   XLEN  redirect target
//  imem_req_valid   out  1     request valid
//  imem_req_ready   in   1     memory accepts request
//  imem_addr        out  XLEN  request address (= PCF)
//  imem_resp_valid  in   1     response data valid (>=1 cycle after accept)
//  imem_resp_data   in   32    fetched instruction
//  InstrD           out  32    instruction to decode
//  PCD              out  XLEN  PC of InstrD
//  PCPlus4D         out  XLEN  PCD+4
//  validD           out  1     InstrD is a real instruction (0 = bubble)
//  fetch_busy       out  1     1 while in WAIT or DROP
//  misalign_trap    out  1     only with FETCH_MISALIGN_TRAP_EN
// BEHAVIOUR
//  Reset: PCF=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0,
//   validD=0, instruction buffer cleared, misalign_trap=0. rst overrides all
//   inputs; an outstanding response arriving after reset is ignored by the
//   memory contract (memory is reset together).
//  Priority per cycle: rst > PCSrcE > flushD > stall > normal progress.
//  FSM states REQ, WAIT, HOLD, DROP:
//   REQ : imem_req_valid = !stallF & !PCSrcE; imem_addr = PCF.
//         PCSrcE -> PCF<=target, stay REQ. req_valid&ready -> WAIT.
//   WAIT: resp_valid & PCSrcE -> discard data, PCF<=target, -> REQ.
//         PCSrcE w/o resp -> PCF<=target, -> DROP.
//         resp_valid & !stallD -> load IF/ID (InstrD=data, PCD=PCF,
//           PCPlus4D=PCF+4, validD=1), PCF<=PCF+4, -> REQ.
//         resp_valid & stallD -> buf<=data, -> HOLD.
//   HOLD: PCSrcE -> drop buf, PCF<=target, -> REQ.
//         !stallD -> load IF/ID from buf, PCF<=PCF+4, -> REQ.
//   DROP: resp_valid -> discard, -> REQ. PCSrcE again -> PCF<=new target.
//  IF/ID register: flushD|PCSrcE -> InstrD=NOP_INSTR, validD=0, PCD/PCPlus4D
//   unchanged; else stallD -> hold; else if no instruction loaded this cycle
//   -> bubble (NOP, validD=0).
//  Best case throughput: 1 instr / 2 cycles per REQ->WAIT round trip with
//   1-cycle memory; latency accept -> InstrD visible = resp cycle + 1.
//  Arithmetic: PCF+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
//  Redirect target low bits: PCF loaded with {PCTargetE[XLEN-1:2],2'b00}.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: misalign_trap port present; registered
//   1-cycle pulse when PCSrcE=1 and PCTargetE[1:0]!=0; PCF still loaded
//   with aligned target.
//  Not defined: port absent, low target bits silently cleared, no trap.
// TESTING
//  1 rst 2 cycles, 1-cycle memory -> first req addr=RESET_PC, InstrD/PCD
//    sequence 0x0,0x4,0x8 with validD=1, bubbles between.
//  2 imem_req_ready low 3 cycles in REQ -> addr held at PCF, no WAIT entry.
//  3 resp arrives with stallD=1 for 2 cycles -> HOLD, InstrD unchanged,
//    loaded on cycle stallD falls; PCF advances by exactly 4.
//  4 PCSrcE=1, PCTargetE=0x100 in WAIT before resp -> DROP, stale resp
//    discarded, next req addr=0x100, InstrD bubble on redirect cycle.
//  5 PCF=32'hFFFF_FFFC fetched -> next req addr=0x0, PCPlus4D=0x0.
//  6 macro on, PCTargetE=0x102 -> misalign_trap=1 one cycle, req addr=0x100;
//    macro off -> no trap, req addr=0x100.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with IF/ID pipeline register.
//
// Purpose: keeps PCF and issues one instruction-memory request at a time over
// a valid/ready request channel. The response comes back on a separate
// response-valid strobe. Fetched words go into the IF/ID register
// (InstrD/PCD/PCPlus4D/validD) under the control of the hazard unit
// (stallF/stallD/flushD) and the EX-stage redirect (PCSrcE/PCTargetE).
// Redirect targets are word-aligned by clearing the two low bits.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stallF, stallD, flushD    hazard-unit controls
//   PCSrcE, PCTargetE         taken branch/jump redirect from EX
//   imem_req_valid/ready      request handshake, imem_addr = PCF
//   imem_resp_valid/data      instruction response (>=1 cycle after accept)
//   InstrD, PCD, PCPlus4D     decode-stage instruction and its PCs
//   validD                    InstrD is real (0 = bubble, NOP_INSTR)
//   fetch_busy                a request is outstanding (WAIT or DROP)
//   misalign_trap             only when FETCH_MISALIGN_TRAP_EN is defined:
//                             1-cycle pulse on a redirect to an unaligned target
//
// Build option: define FETCH_MISALIGN_TRAP_EN to add the misalign_trap port.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD,
  output logic            fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] targetAligned;
  logic [31:0]     instrBuf;
  logic            loadD;
  logic [31:0]     loadData;

  assign pcPlus4F      = PCF + XLEN'(4);
  assign targetAligned = {PCTargetE[XLEN-1:2], 2'b00};

  always_comb begin
    imem_req_valid = (state == REQ) && !stallF && !PCSrcE;
    imem_addr      = PCF;
    fetch_busy     = (state == WAIT) || (state == DROP);
  end

  // A word reaches IF/ID either straight from the response (WAIT) or from
  // the buffer that captured it while decode was stalled (HOLD).
  always_comb begin
    loadD    = 1'b0;
    loadData = imem_resp_data;
    if (!PCSrcE) begin
      case (state)
        WAIT: loadD = imem_resp_valid && !stallD;
        HOLD: begin
          loadD    = !stallD;
          loadData = instrBuf;
        end
        default: loadD = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      PCF      <= RESET_PC;
      instrBuf <= '0;
    end else begin
      case (state)
        REQ: begin
          if (PCSrcE)
            PCF <= targetAligned;
          else if (imem_req_valid && imem_req_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (PCSrcE) begin
            // Response in the same cycle is simply discarded; otherwise the
            // stale response still has to be drained in DROP.
            PCF   <= targetAligned;
            state <= imem_resp_valid ? REQ : DROP;
          end else if (imem_resp_valid) begin
            if (stallD) begin
              instrBuf <= imem_resp_data;
              state    <= HOLD;
            end else begin
              PCF   <= pcPlus4F;
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            PCF   <= targetAligned;
            state <= REQ;
          end else if (!stallD) begin
            PCF   <= pcPlus4F;
            state <= REQ;
          end
        end
        DROP: begin
          if (PCSrcE)
            PCF <= targetAligned;
          if (imem_resp_valid)
            state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // IF/ID register: redirect/flush bubble beats stall; PCs are kept on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (flushD || PCSrcE) begin
      InstrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (loadD) begin
        InstrD   <= loadData;
        PCD      <= PCF;
        PCPlus4D <= pcPlus4F;
        validD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        validD <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)
      misalign_trap <= 1'b0;
    else
      misalign_trap <= PCSrcE && (PCTargetE[1:0] != 2'b00);
  end
`else
  // Low target bits are dropped silently in this build.
  logic unusedTargetLow;
  assign unusedTargetLow = ^PCTargetE[1:0];
`endif

endmodule
